// File: rtl/ptt_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ptt_sched_pkg
// Brief    : Shared state, band and PTT-source encodings for the PTT scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ptt_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEYED = 2'd1,
        GUARD = 2'd2,
        LOCK  = 2'd3
    } state_t;

    localparam logic BAND_144 = 1'b0;
    localparam logic BAND_432 = 1'b1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ptt_debounce.sv
`default_nettype none
// ============================================================================
// Module   : ptt_debounce
// Brief    : 2-FF synchronizer followed by a mismatch-count debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module ptt_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int            CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    // The level flips on the clock that completes DEB_CYC consecutive mismatches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/ptt_sched.sv
`default_nettype none
// ============================================================================
// Module   : ptt_sched
// Brief    : Two-source, two-band PTT arbiter with guard time and time-out lock.
// Revision : 1.0 - initial release
// ============================================================================
module ptt_sched
    import ptt_sched_pkg::*;
#(
    parameter int DEB_CYC   = 4,
    parameter int GUARD_CYC = 8,
    parameter int TOT_CYC   = 1000,
    parameter int LOCK_CYC  = 50
) (
    input  logic clk,
    input  logic reset,
    input  logic ptt_a,
    input  logic ptt_b,
    input  logic band,
    output logic ptt144,
    output logic ptt432,
    output logic busy,
    output logic tot_flag
);

    localparam int            TW         = $clog2(TOT_CYC + 1);
    localparam int            GW         = $clog2(GUARD_CYC + 1);
    localparam int            LW         = $clog2(LOCK_CYC + 1);
    localparam logic [TW-1:0] TOT_MAX    = TW'(TOT_CYC);
    localparam logic [TW-1:0] TOT_LAST   = TW'(TOT_CYC - 1);
    localparam logic [GW-1:0] GUARD_MAX  = GW'(GUARD_CYC);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_CYC);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYC - 1);

    logic          w_deb_a;
    logic          w_deb_b;
    logic          w_act_a;
    logic          w_act_b;
    logic          w_owner_act;
    logic          w_tot_done;
    logic          w_guard_done;
    logic          w_lock_done;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_owner;
    logic          w_owner_nxt;
    logic          r_band;
    logic          w_band_nxt;
    logic [TW-1:0] r_tot_cnt;
    logic [GW-1:0] r_guard_cnt;
    logic [LW-1:0] r_lock_cnt;

    logic          r_ptt144;
    logic          r_ptt432;
    logic          r_busy;
    logic          r_tot_flag;
    logic          w_ptt144_nxt;
    logic          w_ptt432_nxt;
    logic          w_busy_nxt;
    logic          w_tot_flag_nxt;

    ptt_debounce #(.DEB_CYC(DEB_CYC)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (ptt_a),
        .level (w_deb_a)
    );

    ptt_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (ptt_b),
        .level (w_deb_b)
    );

    assign w_act_a     = ~w_deb_a;
    assign w_act_b     = ~w_deb_b;
    assign w_owner_act = (r_owner == SRC_A) ? w_act_a : w_act_b;

    // The current clock counts toward each limit, so a phase lasts exactly N clocks.
    assign w_tot_done   = (r_tot_cnt >= TOT_LAST);
    assign w_guard_done = (r_guard_cnt >= GUARD_LAST);
    assign w_lock_done  = (r_lock_cnt >= LOCK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= SRC_A;
            r_band      <= BAND_144;
            r_tot_cnt   <= '0;
            r_guard_cnt <= '0;
            r_lock_cnt  <= '0;
            r_ptt144    <= 1'b1;
            r_ptt432    <= 1'b1;
            r_busy      <= 1'b0;
            r_tot_flag  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_band     <= w_band_nxt;
            r_ptt144   <= w_ptt144_nxt;
            r_ptt432   <= w_ptt432_nxt;
            r_busy     <= w_busy_nxt;
            r_tot_flag <= w_tot_flag_nxt;

            // Counters idle at zero outside their state, so they start clear on entry.
            if (r_state != KEYED)         r_tot_cnt <= '0;
            else if (r_tot_cnt != TOT_MAX) r_tot_cnt <= r_tot_cnt + TW'(1);

            if (r_state != GUARD)            r_guard_cnt <= '0;
            else if (r_guard_cnt != GUARD_MAX) r_guard_cnt <= r_guard_cnt + GW'(1);

            if (r_state != LOCK)             r_lock_cnt <= '0;
            else if (r_lock_cnt != LOCK_MAX) r_lock_cnt <= r_lock_cnt + LW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_band_nxt  = r_band;
        case (r_state)
            IDLE: begin
                if (w_act_a || w_act_b) begin
                    w_state_nxt = KEYED;
                    w_owner_nxt = w_act_a ? SRC_A : SRC_B;
                    w_band_nxt  = band;
                end
            end
            KEYED: begin
                if (w_tot_done)        w_state_nxt = LOCK;
                else if (!w_owner_act) w_state_nxt = GUARD;
            end
            GUARD: begin
                if (w_guard_done) w_state_nxt = IDLE;
            end
            LOCK: begin
                if (w_lock_done && !w_owner_act) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ptt144_nxt   = 1'b1;
        w_ptt432_nxt   = 1'b1;
        if (w_state_nxt == KEYED) begin
            if (w_band_nxt == BAND_144) w_ptt144_nxt = 1'b0;
            else                        w_ptt432_nxt = 1'b0;
        end
        w_busy_nxt     = (w_state_nxt != IDLE);
        w_tot_flag_nxt = (w_state_nxt == LOCK);
    end

    assign ptt144   = r_ptt144;
    assign ptt432   = r_ptt432;
    assign busy     = r_busy;
    assign tot_flag = r_tot_flag;

endmodule
`default_nettype wire
